// File: rtl/btb_pkg.sv
// btb_pkg: shared types and width helpers for the btb_assoc branch target buffer.
// BTB_ENTRY_T builds the per-entry struct for a given tag/target width.
package btb_pkg;

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    localparam int BTB_W_DEF     = 32;
    localparam int BTB_IDX_W_DEF = 4;
    localparam int BTB_WAYS_DEF  = 4;

    function automatic int tag_w_f(input int w, input int idx_w);
        return w - idx_w - 2;
    endfunction

    function automatic int way_w_f(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

`define BTB_ENTRY_T(TW, TGW) struct packed { \
    logic             valid; \
    logic [(TW)-1:0]  tag; \
    logic [(TGW)-1:0] target; \
}

// File: rtl/btb_assoc_if.sv
// btb_assoc_if: lookup, update, flush and perf-counter bundle of btb_assoc.
// master = fetch/resolve side, slave = the buffer.
interface btb_assoc_if
    import btb_pkg::*;
#(
    parameter int W     = 32,
    parameter int WAYS  = 4,
    parameter int CNT_W = 16
) ();
    localparam int WAY_W = way_w_f(WAYS);

    logic             lu_valid;
    logic [W-1:0]     lu_pc;
    logic             lu_rsp_valid;
    logic             lu_hit;
    logic [W-1:0]     lu_target;
    logic [WAY_W-1:0] lu_way;
    logic             upd_valid;
    logic [W-1:0]     upd_pc;
    logic [W-1:0]     upd_target;
    logic             upd_taken;
    logic             upd_ready;
    logic             flush;
    logic [CNT_W-1:0] perf_lookups;
    logic [CNT_W-1:0] perf_hits;
    logic [CNT_W-1:0] perf_allocs;

    modport master (
        output lu_valid, lu_pc, upd_valid, upd_pc,
        output upd_target, upd_taken, flush,
        input  lu_rsp_valid, lu_hit, lu_target, lu_way,
        input  upd_ready, perf_lookups, perf_hits, perf_allocs
    );

    modport slave (
        input  lu_valid, lu_pc, upd_valid, upd_pc,
        input  upd_target, upd_taken, flush,
        output lu_rsp_valid, lu_hit, lu_target, lu_way,
        output upd_ready, perf_lookups, perf_hits, perf_allocs
    );
endinterface

// File: rtl/btb_lru.sv
// btb_lru: combinational true-LRU for one set.
// Age 0 is most recent; victim is lowest invalid way, else the oldest.
module btb_lru
    import btb_pkg::*;
#(
    parameter  int WAYS  = 4,
    localparam int WAY_W = way_w_f(WAYS)
) (
    input  logic [WAYS-1:0][WAY_W-1:0] age,
    input  logic [WAYS-1:0]            valid,
    input  logic [WAY_W-1:0]           touch,
    output logic [WAYS-1:0][WAY_W-1:0] age_nxt,
    output logic [WAY_W-1:0]           victim
);
    always_comb begin
        age_nxt = age;
        for (int w = 0; w < WAYS; w++) begin
            if (age[w] < age[touch]) begin
                age_nxt[w] = age[w] + 1'b1;
            end
        end
        age_nxt[touch] = '0;
    end

    always_comb begin
        victim = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim = WAY_W'(w);
            end
        end
        if (&valid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age[w] == WAY_W'(WAYS - 1)) begin
                    victim = WAY_W'(w);
                end
            end
        end
    end
endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative BTB, registered lookup, true-LRU, one-set-per-cycle flush.
// Define BTB_PERF_CNT_EN to build saturating lookup/hit/alloc counters.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int W     = 32,
    parameter int IDX_W = 4,
    parameter int WAYS  = 4,
    parameter int CNT_W = 16
) (
    input logic        clk,
    input logic        rst,
    btb_assoc_if.slave bus
);
    localparam int SETS  = 2 ** IDX_W;
    localparam int TAG_W = tag_w_f(W, IDX_W);
    localparam int WAY_W = way_w_f(WAYS);

    typedef `BTB_ENTRY_T(TAG_W, W) entry_t;

    entry_t                     mem   [SETS][WAYS];
    logic [WAYS-1:0][WAY_W-1:0] age_q [SETS];

    state_t           state, state_nxt;
    logic [IDX_W-1:0] fl_set, fl_set_nxt;

    logic [IDX_W-1:0] lu_idx, upd_idx;
    logic [TAG_W-1:0] lu_tag, upd_tag;
    logic             lu_hit_c, upd_hit;
    logic [WAY_W-1:0] lu_way_c, upd_hit_way, upd_way, victim;
    logic [W-1:0]     lu_tgt_c;
    logic [WAYS-1:0]  upd_vvec;
    logic [WAYS-1:0][WAY_W-1:0] age_nxt;
    logic             upd_fire, alloc;
    logic             rsp_q, hit_q;
    logic [W-1:0]     tgt_q;
    logic [WAY_W-1:0] way_q;
    logic             unused_pc;

    assign lu_idx    = bus.lu_pc[2 +: IDX_W];
    assign lu_tag    = bus.lu_pc[W-1 -: TAG_W];
    assign upd_idx   = bus.upd_pc[2 +: IDX_W];
    assign upd_tag   = bus.upd_pc[W-1 -: TAG_W];
    assign unused_pc = ^{bus.lu_pc[1:0], bus.upd_pc[1:0]};

    always_comb begin
        lu_hit_c = 1'b0;
        lu_way_c = '0;
        lu_tgt_c = '0;
        if (bus.lu_valid && state == IDLE) begin
            for (int w = 0; w < WAYS; w++) begin
                if (mem[lu_idx][w].valid && mem[lu_idx][w].tag == lu_tag) begin
                    lu_hit_c = 1'b1;
                    lu_way_c = WAY_W'(w);
                    lu_tgt_c = mem[lu_idx][w].target;
                end
            end
        end
    end

    always_comb begin
        upd_hit     = 1'b0;
        upd_hit_way = '0;
        upd_vvec    = '0;
        for (int w = 0; w < WAYS; w++) begin
            upd_vvec[w] = mem[upd_idx][w].valid;
            if (mem[upd_idx][w].valid && mem[upd_idx][w].tag == upd_tag) begin
                upd_hit     = 1'b1;
                upd_hit_way = WAY_W'(w);
            end
        end
    end

    assign upd_way  = upd_hit ? upd_hit_way : victim;
    assign upd_fire = bus.upd_valid && bus.upd_taken && state == IDLE;
    assign alloc    = upd_fire && !upd_hit;

    btb_lru #(.WAYS(WAYS)) u_lru (
        .age     (age_q[upd_idx]),
        .valid   (upd_vvec),
        .touch   (upd_way),
        .age_nxt (age_nxt),
        .victim  (victim)
    );

    always_comb begin
        state_nxt  = state;
        fl_set_nxt = fl_set;
        unique case (state)
            IDLE: begin
                if (bus.flush) begin
                    state_nxt  = FLUSH;
                    fl_set_nxt = '0;
                end
            end
            FLUSH: begin
                fl_set_nxt = fl_set + 1'b1;
                if (fl_set == IDX_W'(SETS - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            fl_set <= '0;
        end else begin
            state  <= state_nxt;
            fl_set <= fl_set_nxt;
        end
    end

    // A flush clears only valid bits and ages; stale tags are unreachable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    mem[s][w]   <= '0;
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else if (state == FLUSH) begin
            for (int w = 0; w < WAYS; w++) begin
                mem[fl_set][w].valid <= 1'b0;
                age_q[fl_set][w]     <= WAY_W'(w);
            end
        end else if (upd_fire) begin
            mem[upd_idx][upd_way] <= '{valid: 1'b1, tag: upd_tag, target: bus.upd_target};
            age_q[upd_idx]        <= age_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_q <= 1'b0;
            hit_q <= 1'b0;
            tgt_q <= '0;
            way_q <= '0;
        end else begin
            rsp_q <= bus.lu_valid;
            hit_q <= lu_hit_c;
            tgt_q <= lu_tgt_c;
            way_q <= lu_way_c;
        end
    end

    assign bus.lu_rsp_valid = rsp_q;
    assign bus.lu_hit       = hit_q;
    assign bus.lu_target    = tgt_q;
    assign bus.lu_way       = way_q;
    assign bus.upd_ready    = (state == IDLE);

`ifdef BTB_PERF_CNT_EN
    logic [CNT_W-1:0] n_lu, n_hit, n_alloc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_lu    <= '0;
            n_hit   <= '0;
            n_alloc <= '0;
        end else begin
            if (bus.lu_valid && !(&n_lu)) n_lu <= n_lu + 1'b1;
            if (lu_hit_c && !(&n_hit)) n_hit <= n_hit + 1'b1;
            if (alloc && !(&n_alloc)) n_alloc <= n_alloc + 1'b1;
        end
    end

    assign bus.perf_lookups = n_lu;
    assign bus.perf_hits    = n_hit;
    assign bus.perf_allocs  = n_alloc;
`else
    logic unused_alloc;
    assign unused_alloc     = alloc;
    assign bus.perf_lookups = {CNT_W{1'b0}};
    assign bus.perf_hits    = {CNT_W{1'b0}};
    assign bus.perf_allocs  = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: directed plus random stimulus for btb_assoc against an
// LRU-list reference model; lookup responses are matched by a scoreboard.
module tb_btb_assoc;
    localparam int W = 32, IDX_W = 4, WAYS = 4, CNT_W = 16;
    localparam int SETS = 16;

    typedef struct {
        bit          hit;
        logic [31:0] tgt;
        logic [1:0]  way;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    btb_assoc_if #(.W(W), .WAYS(WAYS), .CNT_W(CNT_W)) bus ();

    btb_assoc #(.W(W), .IDX_W(IDX_W), .WAYS(WAYS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    bit          m_valid [SETS][WAYS];
    logic [25:0] m_tag   [SETS][WAYS];
    logic [31:0] m_tgt   [SETS][WAYS];
    int          m_ord   [SETS][$];
    int          m_left;
    int          m_lu, m_hit, m_alloc;
    exp_t        q [$];
    bit          last_ready;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= (1 << CNT_W) - 1) ? v : v + 1;
    endfunction

    function automatic longint perf_exp(input int v);
`ifdef BTB_PERF_CNT_EN
        return longint'(v);
`else
        return 0 * v;
`endif
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < SETS; s++) begin
            m_ord[s].delete();
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_ord[s].push_back(w);
            end
        end
    endfunction

    function automatic void m_touch(input int s, input int k);
        int pos = 0;
        for (int i = 0; i < m_ord[s].size(); i++)
            if (m_ord[s][i] == k) pos = i;
        m_ord[s].delete(pos);
        m_ord[s].push_front(k);
    endfunction

    function automatic exp_t m_lookup(input logic [31:0] pc);
        exp_t e;
        int   s = int'(pc[5:2]);
        e.hit = 1'b0;
        e.tgt = '0;
        e.way = '0;
        if (m_left == 0) begin
            for (int w = 0; w < WAYS; w++) begin
                if (m_valid[s][w] && m_tag[s][w] == pc[31:6]) begin
                    e.hit = 1'b1;
                    e.tgt = m_tgt[s][w];
                    e.way = 2'(w);
                end
            end
        end
        return e;
    endfunction

    function automatic void m_update(input logic [31:0] pc, input logic [31:0] t);
        int s = int'(pc[5:2]);
        int k = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == pc[31:6]) k = w;
        if (k < 0) begin
            for (int w = 0; w < WAYS; w++)
                if (!m_valid[s][w] && k < 0) k = w;
            if (k < 0) k = m_ord[s][WAYS-1];
            m_alloc = sat(m_alloc);
        end
        m_valid[s][k] = 1'b1;
        m_tag[s][k]   = pc[31:6];
        m_tgt[s][k]   = t;
        m_touch(s, k);
    endfunction

    task automatic step(input bit lv, input logic [31:0] lpc, input bit uv,
                        input logic [31:0] upc, input logic [31:0] ut,
                        input bit tk, input bit fl);
        exp_t e;
        @(negedge clk);
        bus.lu_valid   = lv;
        bus.lu_pc      = lpc;
        bus.upd_valid  = uv;
        bus.upd_pc     = upc;
        bus.upd_target = ut;
        bus.upd_taken  = tk;
        bus.flush      = fl;
        last_ready     = bus.upd_ready;
        chk("upd_ready", {63'd0, bus.upd_ready}, {63'd0, m_left == 0});
        if (lv) begin
            e = m_lookup(lpc);
            q.push_back(e);
            m_lu = sat(m_lu);
            if (e.hit) m_hit = sat(m_hit);
        end
        if (uv && tk && m_left == 0) m_update(upc, ut);
        if (m_left > 0) m_left--;
        else if (fl) begin
            m_clear();
            m_left = SETS;
        end
    endtask

    task automatic look(input logic [31:0] pc);
        step(1'b1, pc, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] t);
        step(1'b0, '0, 1'b1, pc, t, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b0;
        bus.lu_valid   = 1'b0;
        bus.lu_pc      = '0;
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = '0;
        bus.upd_target = '0;
        bus.upd_taken  = 1'b0;
        bus.flush      = 1'b0;
        m_clear();
        m_left  = 0;
        m_lu    = 0;
        m_hit   = 0;
        m_alloc = 0;
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("rst_rsp_valid", {63'd0, bus.lu_rsp_valid}, 0);
        chk("rst_hit", {63'd0, bus.lu_hit}, 0);
        chk("rst_target", {32'd0, bus.lu_target}, 0);
        chk("rst_way", {62'd0, bus.lu_way}, 0);
        chk("rst_upd_ready", {63'd0, bus.upd_ready}, 1);
        chk("rst_perf", {16'd0, bus.perf_lookups, bus.perf_hits, bus.perf_allocs}, 0);
    endtask

    task automatic chk_perf();
        chk("perf_lookups", {48'd0, bus.perf_lookups}, perf_exp(m_lu));
        chk("perf_hits", {48'd0, bus.perf_hits}, perf_exp(m_hit));
        chk("perf_allocs", {48'd0, bus.perf_allocs}, perf_exp(m_alloc));
    endtask

    // Scoreboard: a lookup issued before an edge is due right after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                if (bus.lu_rsp_valid) begin
                    if (q.size() == 0) begin
                        chk("rsp_unexpected", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("lu_hit", {63'd0, bus.lu_hit}, {63'd0, e.hit});
                        chk("lu_target", {32'd0, bus.lu_target}, {32'd0, e.tgt});
                        chk("lu_way", {62'd0, bus.lu_way}, {62'd0, e.way});
                    end
                end else if (q.size() != 0) begin
                    chk("rsp_missing", 0, 1);
                    void'(q.pop_front());
                end else begin
                    chk("idle_out", {29'd0, bus.lu_hit, bus.lu_target, bus.lu_way}, 0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        logic [31:0] pc;

        do_reset();
        look(32'h100);
        upd(32'h100, 32'h2000);
        look(32'h100);

        do_reset();
        upd(32'h000, 32'hA000);
        upd(32'h040, 32'hA040);
        upd(32'h080, 32'hA080);
        upd(32'h0C0, 32'hA0C0);
        upd(32'h000, 32'hB000);
        upd(32'h100, 32'hA100);
        look(32'h040);
        look(32'h000);
        look(32'h100);

        step(1'b1, 32'h200, 1'b1, 32'h200, 32'h7777, 1'b1, 1'b0);
        look(32'h200);
        step(1'b0, '0, 1'b1, 32'h300, 32'h1, 1'b0, 1'b0);
        look(32'h300);

        do_reset();
        upd(32'h000, 32'h10);
        upd(32'h044, 32'h20);
        upd(32'h408, 32'h30);
        upd(32'h83C, 32'h40);
        step(1'b1, 32'h044, 1'b0, '0, '0, 1'b0, 1'b1);
        low = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 32'h408, (low < 8), 32'h500, 32'h55, 1'b1, 1'b1);
            if (last_ready) break;
            low++;
        end
        chk("flush_len", low, 16);
        look(32'h000);
        look(32'h044);
        look(32'h408);
        look(32'h83C);
        look(32'h500);

        upd(32'h000, 32'h10);
        step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        repeat (5) look(32'h000);
        do_reset();
        look(32'h000);

        do_reset();
        upd(32'h600, 32'h6000);
        upd(32'h640, 32'h6400);
        look(32'h600);
        look(32'h640);
        look(32'h600);
        for (int i = 0; i < 7; i++) look(32'h700 + 32'(i * 4));
        step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk_perf();
`ifdef BTB_PERF_CNT_EN
        chk("perf_lookups_10", {48'd0, bus.perf_lookups}, 10);
        chk("perf_hits_3", {48'd0, bus.perf_hits}, 3);
        chk("perf_allocs_2", {48'd0, bus.perf_allocs}, 2);
`else
        chk("perf_off", {16'd0, bus.perf_lookups, bus.perf_hits, bus.perf_allocs}, 0);
`endif

        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] lpc, upc;
            int ix;
            ix  = $urandom_range(0, 3);
            lpc = (32'($urandom_range(0, 6)) << 6) | (32'((ix == 3) ? 15 : ix) << 2)
                | 32'($urandom_range(0, 3));
            ix  = $urandom_range(0, 3);
            upc = (32'($urandom_range(0, 6)) << 6) | (32'((ix == 3) ? 15 : ix) << 2)
                | 32'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, lpc, $urandom_range(0, 1) == 1, upc,
                 $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end
        pc = '0;
        step(1'b0, pc, 1'b0, pc, pc, 1'b0, 1'b0);
        step(1'b0, pc, 1'b0, pc, pc, 1'b0, 1'b0);
        chk_perf();
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
